log_ride_tracker: RTL

- Sits directly downstream of the small-log motion block. Consumes its per-log x/y positions once per frame and decides whether the frog is standing on a log.
- Produces the frog's horizontal carry, or a drown event when the frog is in the river band but not on any log.
- Scans the logs serially through an index/mux handshake, so the upstream block's wide position bus is read one log per cycle.
- Result goes to the frog motion/lives logic.

---
 rtl/log_ride_tracker.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/log_ride_tracker.sv
// log_ride_tracker
//
// Decides once per frame whether the frog is standing on a log. The logs
// are examined one per clock through an index/mux handshake with the
// upstream log motion block. The outcome is either a horizontal carry for
// the frog, or a drown event when the frog is in the river band but on no log.
//
// Ports:
//   Clk          system clock
//   Reset        asynchronous, active-low reset
//   frame_tick   one-cycle pulse per frame; starts a scan when idle
//   frog_x       frog left edge (unsigned)
//   frog_y       frog top edge (unsigned)
//   log_sel      index of the log currently examined (drives upstream mux)
//   log_x        signed x of log[log_sel], same-cycle combinational input
//   log_y        y of log[log_sel]
//   busy         high while a scan is in progress
//   on_log       result of the last completed scan (level)
//   hit_idx      lowest-index log hit in the last scan, 0 if none
//   carry_valid  one-cycle pulse: frog is on a log this frame
//   carry_dx     signed carry to apply to frog_x (-LOG_STEP on hit, else 0)
//   drown        one-cycle pulse: frog in river band and on no log
//   overrun      sticky: a frame_tick arrived while a scan was running
module log_ride_tracker #(
  parameter int NUM_LOGS    = 24,
  parameter int LOG_W       = 48,
  parameter int FROG_W      = 32,
  parameter int LOG_STEP    = 1,
  parameter int RIVER_Y_MIN = 48,
  parameter int RIVER_Y_MAX = 168
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic [9:0]         frog_x,
  input  logic [9:0]         frog_y,
  output logic [4:0]         log_sel,
  input  logic signed [10:0] log_x,
  input  logic [9:0]         log_y,
  output logic               busy,
  output logic               on_log,
  output logic [4:0]         hit_idx,
  output logic               carry_valid,
  output logic signed [3:0]  carry_dx,
  output logic               drown,
  output logic               overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

  localparam logic [4:0]         LAST_SEL  = 5'(NUM_LOGS - 1);
  localparam logic signed [11:0] HALF_FROG = 12'(FROG_W / 2);
  localparam logic signed [11:0] LOG_SPAN  = 12'(LOG_W - 1);
  localparam logic signed [3:0]  STEP_NEG  = 4'(-LOG_STEP);
  localparam logic [9:0]         Y_MIN     = 10'(RIVER_Y_MIN);
  localparam logic [9:0]         Y_MAX     = 10'(RIVER_Y_MAX);

  state_t              state_r, state_n;
  logic [9:0]          fx_r, fx_n;
  logic [9:0]          fy_r, fy_n;
  logic [4:0]          sel_r, sel_n;
  logic                hit_r, hit_n;
  logic [4:0]          scan_idx_r, scan_idx_n;
  logic                busy_r, busy_n;
  logic                on_log_r, on_log_n;
  logic [4:0]          hit_idx_r, hit_idx_n;
  logic                cv_r, cv_n;
  logic signed [3:0]   dx_r, dx_n;
  logic                drown_r, drown_n;
  logic                overrun_r, overrun_n;

  logic signed [11:0]  center_s;
  logic signed [11:0]  lx_s;
  logic signed [11:0]  hi_s;
  logic                hit_now_s;
  logic                in_band_s;

  // Overlap test for the log currently on the mux, all at 12-bit signed so
  // logs that have wrapped to negative x compare correctly.
  always_comb begin
    center_s  = $signed({2'b00, fx_r}) + HALF_FROG;
    lx_s      = {log_x[10], log_x};
    hi_s      = lx_s + LOG_SPAN;
    hit_now_s = (log_y == fy_r) && (center_s >= lx_s) && (center_s <= hi_s);
    in_band_s = (fy_r >= Y_MIN) && (fy_r <= Y_MAX);
  end

  // Next-state and next-register logic for the scan controller.
  always_comb begin
    state_n    = state_r;
    fx_n       = fx_r;
    fy_n       = fy_r;
    sel_n      = sel_r;
    hit_n      = hit_r;
    scan_idx_n = scan_idx_r;
    busy_n     = busy_r;
    on_log_n   = on_log_r;
    hit_idx_n  = hit_idx_r;
    cv_n       = 1'b0;
    dx_n       = dx_r;
    drown_n    = 1'b0;
    // A tick is only honoured from IDLE; any other tick is flagged for good.
    overrun_n  = overrun_r | (frame_tick & (state_r != ST_IDLE));

    case (state_r)
      ST_IDLE: begin
        if (frame_tick) begin
          fx_n       = frog_x;
          fy_n       = frog_y;
          sel_n      = 5'd0;
          hit_n      = 1'b0;
          scan_idx_n = 5'd0;
          busy_n     = 1'b1;
          state_n    = ST_SCAN;
        end else begin
          state_n    = ST_IDLE;
        end
      end

      ST_SCAN: begin
        // Only the first hit is recorded so the lowest index wins.
        if (hit_now_s && !hit_r) begin
          hit_n      = 1'b1;
          scan_idx_n = sel_r;
        end else begin
          hit_n      = hit_r;
        end
        if (sel_r == LAST_SEL) begin
          state_n = ST_RESOLVE;
        end else begin
          sel_n   = sel_r + 5'd1;
        end
      end

      ST_RESOLVE: begin
        on_log_n  = hit_r;
        hit_idx_n = hit_r ? scan_idx_r : 5'd0;
        if (hit_r) begin
          cv_n    = 1'b1;
          dx_n    = STEP_NEG;
        end else if (in_band_s) begin
          drown_n = 1'b1;
          dx_n    = 4'sd0;
        end else begin
          dx_n    = 4'sd0;
        end
        busy_n  = 1'b0;
        sel_n   = 5'd0;
        state_n = ST_IDLE;
      end

      default: begin
        busy_n  = 1'b0;
        sel_n   = 5'd0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fx_r       <= 10'd0;
      fy_r       <= 10'd0;
      sel_r      <= 5'd0;
      hit_r      <= 1'b0;
      scan_idx_r <= 5'd0;
      busy_r     <= 1'b0;
      on_log_r   <= 1'b0;
      hit_idx_r  <= 5'd0;
      cv_r       <= 1'b0;
      dx_r       <= 4'sd0;
      drown_r    <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      fx_r       <= fx_n;
      fy_r       <= fy_n;
      sel_r      <= sel_n;
      hit_r      <= hit_n;
      scan_idx_r <= scan_idx_n;
      busy_r     <= busy_n;
      on_log_r   <= on_log_n;
      hit_idx_r  <= hit_idx_n;
      cv_r       <= cv_n;
      dx_r       <= dx_n;
      drown_r    <= drown_n;
      overrun_r  <= overrun_n;
    end
  end

  assign log_sel     = sel_r;
  assign busy        = busy_r;
  assign on_log      = on_log_r;
  assign hit_idx     = hit_idx_r;
  assign carry_valid = cv_r;
  assign carry_dx    = dx_r;
  assign drown       = drown_r;
  assign overrun     = overrun_r;

endmodule
